alu_seq_responder: RTL and testbench
====================================

# alu_seq_responder

Multi-cycle 64-bit Y86 OPq execute unit with a start/done handshake, for the SEQ Execute stage. It accepts one operation per request and computes valE serially in SLICE-bit slices, carrying between slices. It then returns valE with the Y86 condition codes ZF, SF and OF. It answers the requester side that drives A, B and ifun and waits for the result.

## Interface
- SLICE, 16, slice width in bits; legal values 8, 16, 32, 64; N = 64/SLICE cycles per operation
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- ifun  input  4  0=ADD (B+A), 1=SUB (B−A), 2=AND, 3=XOR; others illegal
- A  input  64  operand valA
- B  input  64  operand valB
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; valE, flags and err are valid
- valE  output  64  result; held until the next done
- zf, sf, of  output  1 each  condition codes; held until the next done
- err  output  1  high with done when ifun was illegal; held until the next done

## Operation
- One clock (clk); reset is synchronous and active-high (rst).
- FSM states are IDLE, RUN and DONE; the reset state is IDLE.
- IDLE or DONE with start=1: latch A, B, ifun; clear slice counter; go to RUN.
- DONE with start=0: go to IDLE.
- RUN: each cycle process slice cnt, bits [cnt*SLICE +: SLICE], into the internal result register.
- RUN, cnt=N−1: go to DONE and update the outputs.
- start in RUN is ignored; no queueing.
- Operands are latched, so changes on A, B or ifun after acceptance have no effect.
- ADD: slice sum with a carry register; carry-in is 0 for slice 0.
- SUB: B + ~A + 1; carry-in is 1 for slice 0; carry propagates between slices.
- AND and XOR: bitwise per slice; no carry.
- All arithmetic is modulo 2^64.
- Flags are computed from the full 64-bit result:
  - zf = (valE==0); sf = valE[63]
  - ADD: of = (A[63]==B[63]) & (valE[63]!=A[63])
  - SUB: of = (A[63]!=B[63]) & (valE[63]!=B[63])
  - AND and XOR: of = 0
- Illegal ifun: the same latency applies. At done, valE=0, err=1, and zf/sf/of keep their previous values.
- Legal ifun at done: err=0.

## Timing
- Reset values:
  - state IDLE; busy=0; done=0; valE=0
  - zf=1, sf=0, of=0 (Y86 CC reset); err=0
  - carry and counter cleared
- rst overrides all other inputs, including start.
- rst mid-RUN aborts the operation: no done pulse, outputs take their reset values.
- Latency: start sampled at edge k → busy=1 after edges k..k+N−1 → done=1 and outputs updated after edge k+N → done=0 after edge k+N+1.
- With SLICE=16, done arrives 4 cycles after the start edge.
- busy and done are registered and never high together.
- Back-to-back: start held during the DONE cycle is accepted at that edge, giving one operation per N+1 cycles.
- SLICE=64: N=1; the operation completes in a single RUN cycle with the same state sequence.

## Test plan
- XOR, SLICE=16: A=0xCCCCCCCCCCCCCCCC, B=0xAAAAAAAAAAAAAAAA, ifun=3, one-cycle start.
  - Required: valE=0x6666666666666666, zf=0, sf=0, of=0, err=0.
  - Required: done exactly 4 cycles after start; busy high for 4 cycles before it.
  - Repeat with A=0xF0F0F0F0F0F0F0F0, B=0x0F0F0F0F0F0F0F0F: valE=0xFFFFFFFFFFFFFFFF, sf=1.
- ADD, carry chain and overflow: A=0x7FFFFFFFFFFFFFFF, B=1.
  - Required: valE=0x8000000000000000, sf=1, of=1, zf=0.
  - Also A=0xFFFFFFFFFFFFFFFF, B=1: valE=0, zf=1, of=0.
- SUB:
  - A=B=0x123456789ABCDEF0: valE=0, zf=1, sf=0, of=0.
  - A=1, B=0: valE=0xFFFFFFFFFFFFFFFF, sf=1, of=0.
  - A=1, B=0x8000000000000000: valE=0x7FFFFFFFFFFFFFFF, of=1.
- Handshake:
  - start pulses while busy, and operands change during RUN: ignored, result reflects the latched operands.
  - start held through DONE: the second operation is accepted, and its done follows N+1 cycles after the first done.
- Reset mid-op: start an ADD, assert rst for one cycle at the 2nd RUN cycle.
  - Required: no done pulse; busy=0, zf=1, valE=0.
  - Required: a following AND of A=0xFF00, B=0x0FF0 gives valE=0x0F00.
- Illegal ifun=5 after a SUB that set zf=1.
  - Required: done after 4 cycles with err=1, valE=0, zf still 1.
  - Required: the next legal op clears err.

Source files
------------

// File: rtl/alu_seq_responder.sv
// alu_seq_responder: multi-cycle sliced Y86 OPq execute unit with start/done handshake
module alu_seq_responder #(
  parameter int SLICE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ifun,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] valE,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        err
);
  localparam int N = 64 / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic [3:0] fn_q, fn_d;
  logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d, val_e_q, val_e_d;
  logic zf_q, zf_d, sf_q, sf_d, of_q, of_d, err_q, err_d;
  logic [SLICE-1:0] a_s, b_s, slice_r;
  logic [SLICE:0] sum;
  logic sub, cin, last, legal;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign valE = val_e_q;
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
  assign err = err_q;
  // Slice datapath, FSM sequencing and result/flag capture on the last slice
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    fn_d = fn_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    val_e_d = val_e_q;
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    err_d = err_q;
    a_s = a_q[cnt_q*SLICE +: SLICE];
    b_s = b_q[cnt_q*SLICE +: SLICE];
    sub = fn_q == 4'd1;
    cin = (cnt_q == '0) ? sub : carry_q;
    sum = {1'b0, b_s} + {1'b0, sub ? ~a_s : a_s} + {{SLICE{1'b0}}, cin};
    slice_r = (fn_q == 4'd2) ? (a_s & b_s) : (fn_q == 4'd3) ? (a_s ^ b_s) : sum[SLICE-1:0];
    last = cnt_q == CW'(N - 1);
    legal = fn_q < 4'd4;
    if (state_q == RUN) begin
      res_d[cnt_q*SLICE +: SLICE] = slice_r;
      carry_d = sum[SLICE];
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        val_e_d = legal ? res_d : 64'd0;
        err_d = !legal;
        if (legal) begin
          zf_d = res_d == 64'd0;
          sf_d = res_d[63];
          of_d = (fn_q == 4'd0) ? ((a_q[63] == b_q[63]) && (res_d[63] != a_q[63])) :
                 (fn_q == 4'd1) ? ((a_q[63] != b_q[63]) && (res_d[63] != b_q[63])) : 1'b0;
        end
      end
    end else begin
      state_d = start ? RUN : IDLE;
      if (start) begin
        a_d = A;
        b_d = B;
        fn_d = ifun;
        cnt_d = '0;
        carry_d = 1'b0;
        res_d = 64'd0;
      end
    end
  end
  // State and output registers; Y86 CC reset leaves zf set
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      carry_q <= 1'b0;
      fn_q <= 4'd0;
      a_q <= 64'd0;
      b_q <= 64'd0;
      res_q <= 64'd0;
      val_e_q <= 64'd0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      fn_q <= fn_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      val_e_q <= val_e_d;
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: scoreboard bench for the sliced Y86 execute unit
module tb_alu_seq_responder;
  localparam int SLICE = 16;
  localparam int N = 64 / SLICE;
  typedef struct {
    logic [63:0] v;
    logic z, s, o, e;
    int c;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] ifun = 0;
  logic [63:0] A = 0, B = 0;
  logic busy, done, zf, sf, of, err;
  logic [63:0] valE;
  int vec = 0, bad = 0, cyc = 0;
  logic mz = 1, ms = 0, mo = 0;
  exp_t q[$];
  exp_t m;
  alu_seq_responder #(.SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .start(start), .ifun(ifun), .A(A), .B(B),
    .busy(busy), .done(done), .valE(valE), .zf(zf), .sf(sf), .of(of), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b, input bit push);
    int t = 0;
    logic [63:0] r;
    logic o;
    exp_t e;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    ifun = f;
    A = a;
    B = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    if (push) begin
      r = 64'd0;
      o = 0;
      case (f)
        4'd0: begin r = b + a; o = (a[63] == b[63]) && (r[63] != a[63]); end
        4'd1: begin r = b - a; o = (a[63] != b[63]) && (r[63] != b[63]); end
        4'd2: r = a & b;
        4'd3: r = a ^ b;
        default: r = 64'd0;
      endcase
      if (f < 4) begin
        mz = r == 64'd0;
        ms = r[63];
        mo = o;
      end
      e.v = r;
      e.z = mz;
      e.s = ms;
      e.o = mo;
      e.e = f >= 4;
      e.c = cyc + N;
      q.push_back(e);
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        m = q.pop_front();
        chk("valE", valE, m.v);
        chk("zf", 64'(zf), 64'(m.z));
        chk("sf", 64'(sf), 64'(m.s));
        chk("of", 64'(of), 64'(m.o));
        chk("err", 64'(err), 64'(m.e));
        chk("latency", 64'(cyc), 64'(m.c));
        chk("busy_with_done", 64'(busy), 64'd0);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valE", valE, 64'd0);
    chk("rst_zf", 64'(zf), 64'd1);
    chk("rst_sf", 64'(sf), 64'd0);
    chk("rst_of", 64'(of), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    op(4'd3, 64'hCCCCCCCCCCCCCCCC, 64'hAAAAAAAAAAAAAAAA, 1);
    for (int i = 0; i < N; i++) begin
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
    end
    drain();
    op(4'd3, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1); drain();
    op(4'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1); drain();
    op(4'd0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1); drain();
    op(4'd1, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1); drain();
    op(4'd1, 64'd1, 64'd0, 1); drain();
    op(4'd1, 64'd1, 64'h8000000000000000, 1); drain();
    op(4'd0, 64'h00000000FFFF0001, 64'h000000000000FFFF, 1);
    start = 1; A = 64'h1234; B = 64'h9999; ifun = 4'd3;
    @(posedge clk);
    #1 A = 64'hDEAD; B = 64'hBEEF; ifun = 4'd2;
    @(posedge clk);
    #1 start = 0;
    drain();
    op(4'd0, 64'h0000FFFF0000FFFF, 64'h0000000100000001, 1);
    for (int t = 0; t < 50 && !done; t++) @(negedge clk);
    op(4'd1, 64'h5, 64'h3, 1);
    drain();
    op(4'd0, 64'h55, 64'h66, 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    mz = 1; ms = 0; mo = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_valE", valE, 64'd0);
    chk("abort_zf", 64'(zf), 64'd1);
    repeat (2 * N) @(negedge clk);
    op(4'd2, 64'hFF00, 64'h0FF0, 1); drain();
    op(4'd1, 64'h77, 64'h77, 1); drain();
    op(4'd5, 64'h1, 64'h2, 1); drain();
    op(4'd2, 64'h3, 64'h6, 1); drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
